// File: rtl/vsd_multi_timer.sv
// Multi-channel down-counting timer with per-channel prescaler, one-shot/periodic
// modes, sticky W1C timeout flags and a maskable aggregated interrupt.
module vsd_multi_timer #(
   parameter int unsigned NUM_CH  = 4,
   parameter int unsigned CNT_W   = 32,
   parameter int unsigned PRESC_W = 16
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              sel,
   input  logic              we,
   input  logic [31:0]       addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata,
   output logic [NUM_CH-1:0] timeout,
   output logic              irq
);

   localparam int unsigned PRESC_LSB = 16;

   logic [NUM_CH-1:0]              en_q, en_d;
   logic [NUM_CH-1:0]              mode_q, mode_d;
   logic [NUM_CH-1:0]              ie_q, ie_d;
   logic [NUM_CH-1:0]              flag_q, flag_d;
   logic [NUM_CH-1:0][PRESC_W-1:0] presc_q, presc_d;
   logic [NUM_CH-1:0][PRESC_W-1:0] pcnt_q, pcnt_d;
   logic [NUM_CH-1:0][CNT_W-1:0]   load_q, load_d;
   logic [NUM_CH-1:0][CNT_W-1:0]   count_q, count_d;

   logic              wr, rd, ch_space, irq_space;
   logic [3:0]        ch_idx;
   logic [1:0]        reg_idx;
   logic [NUM_CH-1:0] ch_hit;
   logic [NUM_CH-1:0] tick;
   logic              unused_bus;

   assign wr        = sel & we;
   assign rd        = sel & ~we;
   assign ch_space  = ~addr[8];
   assign irq_space = addr[8] & (addr[7:2] == 6'd0);
   assign ch_idx    = addr[7:4];
   assign reg_idx   = addr[3:2];
   assign unused_bus = ^{addr[31:9], addr[1:0], wdata};

   // Channel select and prescaler tick; out-of-range channel indices never hit.
   always_comb begin
      ch_hit = '0;
      tick   = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         ch_hit[i] = ch_space && (ch_idx == 4'(i));
         tick[i]   = en_q[i] && (pcnt_q[i] == presc_q[i]);
      end
   end

   // Next state: counting first, then bus writes, then flag set so a set beats a W1C.
   always_comb begin
      en_d    = en_q;
      mode_d  = mode_q;
      ie_d    = ie_q;
      flag_d  = flag_q;
      presc_d = presc_q;
      pcnt_d  = pcnt_q;
      load_d  = load_q;
      count_d = count_q;
      for (int i = 0; i < NUM_CH; i++) begin
         if (en_q[i]) begin
            pcnt_d[i] = tick[i] ? '0 : pcnt_q[i] + PRESC_W'(1);
         end
         if (tick[i]) begin
            if (count_q[i] != '0) begin
               count_d[i] = count_q[i] - CNT_W'(1);
            end else if (mode_q[i]) begin
               count_d[i] = load_q[i];
            end else begin
               en_d[i] = 1'b0;
            end
         end
         if (wr && ch_hit[i]) begin
            case (reg_idx)
               2'd0: begin
                  en_d[i]    = wdata[0];
                  mode_d[i]  = wdata[1];
                  ie_d[i]    = wdata[2];
                  presc_d[i] = wdata[PRESC_LSB +: PRESC_W];
                  if (wdata[0] && !en_q[i]) begin
                     count_d[i] = load_q[i];
                     pcnt_d[i]  = '0;
                  end
               end
               2'd1: load_d[i] = wdata[CNT_W-1:0];
               2'd3: if (wdata[0]) flag_d[i] = 1'b0;
               default: ;
            endcase
         end
         if (tick[i] && (count_q[i] == '0)) begin
            flag_d[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         en_q    <= '0;
         mode_q  <= '0;
         ie_q    <= '0;
         flag_q  <= '0;
         presc_q <= '0;
         pcnt_q  <= '0;
         load_q  <= '0;
         count_q <= '0;
      end else begin
         en_q    <= en_d;
         mode_q  <= mode_d;
         ie_q    <= ie_d;
         flag_q  <= flag_d;
         presc_q <= presc_d;
         pcnt_q  <= pcnt_d;
         load_q  <= load_d;
         count_q <= count_d;
      end
   end

   // Zero-wait-state read mux.
   always_comb begin
      rdata = '0;
      if (rd) begin
         if (irq_space) begin
            rdata = 32'(flag_q);
         end
         for (int i = 0; i < NUM_CH; i++) begin
            if (ch_hit[i]) begin
               case (reg_idx)
                  2'd0: begin
                     rdata[0] = en_q[i];
                     rdata[1] = mode_q[i];
                     rdata[2] = ie_q[i];
                     rdata[PRESC_LSB +: PRESC_W] = presc_q[i];
                  end
                  2'd1:    rdata = 32'(load_q[i]);
                  2'd2:    rdata = 32'(count_q[i]);
                  default: rdata[0] = flag_q[i];
               endcase
            end
         end
      end
   end

   assign timeout = flag_q;
   assign irq     = |(flag_q & ie_q);

endmodule

// File: tb/tb_vsd_multi_timer.sv
// Self-checking bench for vsd_multi_timer: directed scenarios plus randomized
// channel runs checked against closed-form timing arithmetic.
module tb_vsd_multi_timer;

   localparam int NUM_CH = 4;

   logic              clk;
   logic              resetn;
   logic              sel;
   logic              we;
   logic [31:0]       addr;
   logic [31:0]       wdata;
   logic [31:0]       rdata;
   logic [NUM_CH-1:0] timeout;
   logic              irq;

   int unsigned cyc = 0;
   int n_checks = 0;
   int n_pass   = 0;

   vsd_multi_timer #(.NUM_CH(4), .CNT_W(32), .PRESC_W(16)) dut (
      .clk(clk), .resetn(resetn), .sel(sel), .we(we), .addr(addr),
      .wdata(wdata), .rdata(rdata), .timeout(timeout), .irq(irq)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Called in the low clock phase; the write is sampled at the next rising edge.
   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      sel = 1'b1; we = 1'b1; addr = a; wdata = d;
      @(negedge clk);
      sel = 1'b0; we = 1'b0; addr = '0; wdata = '0;
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] d);
      sel = 1'b1; we = 1'b0; addr = a;
      #1;
      d = rdata;
      sel = 1'b0; addr = '0;
   endtask

   task automatic wait_flag(input logic [1:0] ch, input int budget,
                            output int unsigned at, output bit ok);
      ok = 1'b0;
      at = 0;
      for (int k = 0; k < budget; k++) begin
         if (timeout[ch]) begin
            ok = 1'b1;
            at = cyc;
            return;
         end
         @(negedge clk);
      end
   endtask

   // Expected COUNT a given number of edges after the enabling write.
   function automatic int unsigned model_count(int unsigned l, int unsigned p,
                                               bit mode, int unsigned k);
      int unsigned period = (l + 1) * (p + 1);
      if (!mode && k >= period) return 0;
      return l - (k % period) / (p + 1);
   endfunction

   task automatic test_reset();
      logic [31:0] d;
      for (int i = 0; i < NUM_CH; i++) begin
         wr(32'(i * 16 + 4), $urandom_range(0, 20));
         wr(32'(i * 16), $urandom);
      end
      repeat (5) @(negedge clk);
      resetn = 1'b0;
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      n_checks++;
      if (timeout !== 4'b0) $display("FAIL reset_timeout: got %b want 0", timeout);
      else n_pass++;
      n_checks++;
      if (irq !== 1'b0) $display("FAIL reset_irq: got %b want 0", irq);
      else n_pass++;
      for (int i = 0; i < NUM_CH; i++) begin
         for (int r = 0; r < 4; r++) begin
            rd(32'(i * 16 + r * 4), d);
            n_checks++;
            if (d !== 32'h0) $display("FAIL reset_reg ch%0d r%0d: got %h want 0", i, r, d);
            else n_pass++;
            @(negedge clk);
         end
      end
      rd(32'h100, d);
      n_checks++;
      if (d !== 32'h0) $display("FAIL reset_irq_status: got %h want 0", d);
      else n_pass++;
   endtask

   task automatic test_oneshot();
      int unsigned t0, at;
      bit ok;
      logic [31:0] d;
      wr(32'h04, 32'd5);
      wr(32'h00, 32'h1);
      t0 = cyc;
      wait_flag(2'd0, 50, at, ok);
      n_checks++;
      if (!ok || at - t0 != 6) $display("FAIL oneshot_latency: got ok=%0d lat=%0d want 6", ok, at - t0);
      else n_pass++;
      rd(32'h00, d);
      n_checks++;
      if (d !== 32'h0) $display("FAIL oneshot_ctrl: got %h want 0", d);
      else n_pass++;
      rd(32'h08, d);
      n_checks++;
      if (d !== 32'h0) $display("FAIL oneshot_count: got %h want 0", d);
      else n_pass++;
      repeat (5) @(negedge clk);
      n_checks++;
      if (timeout !== 4'b0001) $display("FAIL oneshot_sticky: got %b want 0001", timeout);
      else n_pass++;
      wr(32'h0C, 32'h1);
      n_checks++;
      if (timeout !== 4'b0000) $display("FAIL oneshot_clear: got %b want 0000", timeout);
      else n_pass++;
   endtask

   task automatic test_periodic();
      int unsigned t0, at;
      bit ok;
      logic [31:0] d;
      wr(32'h14, 32'd3);
      wr(32'h10, 32'h0001_0003);
      t0 = cyc;
      wait_flag(2'd1, 50, at, ok);
      n_checks++;
      if (!ok || at - t0 != 8) $display("FAIL periodic_first: got ok=%0d lat=%0d want 8", ok, at - t0);
      else n_pass++;
      wr(32'h1C, 32'h1);
      n_checks++;
      if (timeout[1] !== 1'b0) $display("FAIL periodic_clear: got %b want 0", timeout[1]);
      else n_pass++;
      wait_flag(2'd1, 50, at, ok);
      n_checks++;
      if (!ok || at - t0 != 16) $display("FAIL periodic_second: got ok=%0d lat=%0d want 16", ok, at - t0);
      else n_pass++;
      rd(32'h1C, d);
      n_checks++;
      if (d !== 32'h1) $display("FAIL periodic_status: got %h want 1", d);
      else n_pass++;
      wr(32'h10, 32'h0);
      wr(32'h1C, 32'h1);
   endtask

   task automatic test_irq_mask();
      int unsigned t0, at;
      bit ok;
      logic [31:0] d;
      wr(32'h24, 32'd2);
      wr(32'h20, 32'h1);
      t0 = cyc;
      wait_flag(2'd2, 50, at, ok);
      n_checks++;
      if (!ok || at - t0 != 3) $display("FAIL irq_flag_latency: got ok=%0d lat=%0d want 3", ok, at - t0);
      else n_pass++;
      n_checks++;
      if (irq !== 1'b0) $display("FAIL irq_masked: got %b want 0", irq);
      else n_pass++;
      rd(32'h100, d);
      n_checks++;
      if (d !== 32'h4) $display("FAIL irq_status: got %h want 4", d);
      else n_pass++;
      wr(32'h20, 32'h4);
      n_checks++;
      if (irq !== 1'b1) $display("FAIL irq_unmasked: got %b want 1", irq);
      else n_pass++;
      wr(32'h2C, 32'h1);
      n_checks++;
      if (irq !== 1'b0) $display("FAIL irq_after_clear: got %b want 0", irq);
      else n_pass++;
      wr(32'h20, 32'h0);
   endtask

   task automatic test_collision();
      logic [31:0] d;
      wr(32'h04, 32'd2);
      wr(32'h00, 32'h1);
      repeat (2) @(negedge clk);
      n_checks++;
      if (timeout[0] !== 1'b0) $display("FAIL collide_pre: got %b want 0", timeout[0]);
      else n_pass++;
      wr(32'h0C, 32'h1);
      rd(32'h0C, d);
      n_checks++;
      if (d !== 32'h1) $display("FAIL collide_set_wins: got %h want 1", d);
      else n_pass++;
      wr(32'h0C, 32'h1);
      n_checks++;
      if (timeout !== 4'b0) $display("FAIL collide_clear: got %b want 0", timeout);
      else n_pass++;
   endtask

   task automatic test_reset_mid_unmapped();
      logic [31:0] d;
      wr(32'h34, 32'd1000);
      wr(32'h30, 32'h1);
      repeat (4) @(negedge clk);
      rd(32'h38, d);
      n_checks++;
      if (d !== 32'd996) $display("FAIL mid_count_before: got %0d want 996", d);
      else n_pass++;
      resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      rd(32'h38, d);
      n_checks++;
      if (d !== 32'h0) $display("FAIL mid_count_after: got %h want 0", d);
      else n_pass++;
      rd(32'h30, d);
      n_checks++;
      if (d !== 32'h0) $display("FAIL mid_ctrl_after: got %h want 0", d);
      else n_pass++;
      repeat (20) @(negedge clk);
      n_checks++;
      if (timeout !== 4'b0) $display("FAIL mid_no_timeout: got %b want 0", timeout);
      else n_pass++;
      rd(32'h0F0, d);
      n_checks++;
      if (d !== 32'h0) $display("FAIL unmapped_read: got %h want 0", d);
      else n_pass++;
      wr(32'h0F4, 32'hFFFF_FFFF);
      rd(32'h0F4, d);
      n_checks++;
      if (d !== 32'h0) $display("FAIL unmapped_write: got %h want 0", d);
      else n_pass++;
      wr(32'h100, 32'hF);
      rd(32'h100, d);
      n_checks++;
      if (d !== 32'h0) $display("FAIL irq_status_ro: got %h want 0", d);
      else n_pass++;
      wr(32'h38, 32'd77);
      rd(32'h38, d);
      n_checks++;
      if (d !== 32'h0) $display("FAIL count_ro: got %h want 0", d);
      else n_pass++;
   endtask

   task automatic test_random();
      logic [1:0]  ch;
      logic [31:0] base, ctrl, d;
      int unsigned l, p, k, period, exp_cnt, frz_cnt;
      bit          mode, ie, exp_flag;
      logic [3:0]  exp_to;
      for (int it = 0; it < 24; it++) begin
         ch     = 2'($urandom_range(0, 3));
         base   = 32'(ch) << 4;
         l      = $urandom_range(0, 10);
         p      = $urandom_range(0, 3);
         mode   = 1'($urandom_range(0, 1));
         ie     = 1'($urandom_range(0, 1));
         period = (l + 1) * (p + 1);
         k      = $urandom_range(1, 2 * period + 2);
         ctrl   = (32'(p) << 16) | (32'(ie) << 2) | (32'(mode) << 1);
         wr(base + 32'h4, 32'(l));
         wr(base, ctrl | 32'h1);
         repeat (k) @(negedge clk);
         exp_cnt  = model_count(l, p, mode, k);
         exp_flag = (k >= period);
         exp_to   = exp_flag ? (4'b0001 << ch) : 4'b0000;
         rd(base + 32'h8, d);
         n_checks++;
         if (d !== 32'(exp_cnt)) $display("FAIL rand_count it%0d ch%0d L%0d P%0d M%0d k%0d: got %0d want %0d", it, ch, l, p, mode, k, d, exp_cnt);
         else n_pass++;
         rd(base, d);
         n_checks++;
         if (d !== (ctrl | 32'((mode || k < period) ? 1 : 0))) $display("FAIL rand_ctrl it%0d: got %h", it, d);
         else n_pass++;
         n_checks++;
         if (timeout !== exp_to || irq !== (exp_flag & ie)) $display("FAIL rand_flags it%0d: got to=%b irq=%b want to=%b irq=%b", it, timeout, irq, exp_to, exp_flag & ie);
         else n_pass++;
         // Disabling lets the tick on the write edge land, then COUNT must hold.
         wr(base, ctrl);
         frz_cnt = model_count(l, p, mode, k + 1);
         repeat (3) @(negedge clk);
         rd(base + 32'h8, d);
         n_checks++;
         if (d !== 32'(frz_cnt)) $display("FAIL rand_freeze it%0d: got %0d want %0d", it, d, frz_cnt);
         else n_pass++;
         wr(base + 32'hC, 32'h1);
         n_checks++;
         if (timeout !== 4'b0) $display("FAIL rand_clear it%0d: got %b want 0", it, timeout);
         else n_pass++;
      end
   endtask

   initial begin
      resetn = 1'b0;
      sel    = 1'b0;
      we     = 1'b0;
      addr   = '0;
      wdata  = '0;
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      test_reset();
      test_oneshot();
      test_periodic();
      test_irq_mask();
      test_collision();
      test_reset_mid_unmapped();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
